// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift ops plus
// iterative signed multiply and divide behind a valid/ready handshake.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               ctrl_reset_n,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic               ctrl_valid,
    output logic               ctrl_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_valid,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               div_by_zero
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [4:0] OP_SRL = 5'b01000;
    localparam logic [4:0] OP_XOR = 5'b01001;

    localparam logic [WIDTH-1:0]   MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHAMT_W-1:0] LAST_CNT = SHAMT_W'(WIDTH-1);

    typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_q, b_q;
    logic               is_div_q;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   hi, lo, bmag;
    logic [WIDTH-1:0]   hi_n, lo_n;

    logic accept, is_mul, is_div, b_zero, start_iter;

    assign ctrl_ready = (state == IDLE);
    assign accept     = ctrl_valid && ctrl_ready;
    assign is_mul     = (ctrl_ALUopcode == OP_MUL);
    assign is_div     = (ctrl_ALUopcode == OP_DIV);
    assign b_zero     = (data_operandB == '0);
    assign start_iter = accept && (is_mul || (is_div && !b_zero));

    // Comparison flags share one subtractor: live inputs on accept,
    // latched operands when an iterative op completes.
    logic [WIDTH-1:0] cmp_a, cmp_b, diff;
    logic             sub_ovf, lt, ne;

    assign cmp_a   = (state == IDLE) ? data_operandA : a_q;
    assign cmp_b   = (state == IDLE) ? data_operandB : b_q;
    assign diff    = cmp_a - cmp_b;
    assign sub_ovf = (cmp_a[WIDTH-1] != cmp_b[WIDTH-1]) &&
                     (diff[WIDTH-1] != cmp_a[WIDTH-1]);
    assign lt      = diff[WIDTH-1] ^ sub_ovf;
    assign ne      = (cmp_a != cmp_b);

    logic [WIDTH-1:0] sum;
    logic             add_ovf;

    assign sum     = data_operandA + data_operandB;
    assign add_ovf = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                     (sum[WIDTH-1] != data_operandA[WIDTH-1]);

    logic [WIDTH-1:0] res1;
    logic             ovf1, dbz1, known;

    always_comb begin
        res1  = '0;
        ovf1  = 1'b0;
        dbz1  = 1'b0;
        known = 1'b1;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                res1 = sum;
                ovf1 = add_ovf;
            end
            OP_SUB: begin
                res1 = diff;
                ovf1 = sub_ovf;
            end
            OP_AND: res1 = data_operandA & data_operandB;
            OP_OR:  res1 = data_operandA | data_operandB;
            OP_XOR: res1 = data_operandA ^ data_operandB;
            OP_SLL: res1 = data_operandA << ctrl_shiftamt;
            OP_SRL: res1 = data_operandA >> ctrl_shiftamt;
            OP_SRA: res1 = $signed(data_operandA) >>> ctrl_shiftamt;
            OP_MUL: res1 = '0;
            OP_DIV: dbz1 = 1'b1;
            default: known = 1'b0;
        endcase
    end

    logic [WIDTH-1:0] amag_in, bmag_in;

    assign amag_in = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign bmag_in = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // One iteration: shift-add for mul, restoring subtract for div.
    logic [WIDTH:0] shifted, trial, msum;

    always_comb begin
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted - {1'b0, bmag};
        msum    = {1'b0, hi} + (lo[0] ? {1'b0, bmag} : '0);
        hi_n    = hi;
        lo_n    = lo;
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                hi_n = trial[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = msum[WIDTH:1];
            lo_n = {msum[0], lo[WIDTH-1:1]};
        end
    end

    logic             neg;
    logic [2*WIDTH-1:0] sprod;
    logic [WIDTH-1:0] quo;
    logic             mul_ovf, div_ovf;

    assign neg     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    assign sprod   = neg ? -{hi, lo} : {hi, lo};
    assign mul_ovf = (sprod[2*WIDTH-1:WIDTH] != {WIDTH{sprod[WIDTH-1]}});
    assign quo     = neg ? -lo : lo;
    assign div_ovf = (a_q == MIN_VAL) && (b_q == '1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_iter) state_nxt = BUSY;
            BUSY:   if (cnt == LAST_CNT) state_nxt = FINISH;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) state <= IDLE;
        else               state <= state_nxt;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            bmag     <= '0;
        end else if (start_iter) begin
            a_q      <= data_operandA;
            b_q      <= data_operandB;
            is_div_q <= is_div;
            cnt      <= '0;
            hi       <= '0;
            lo       <= amag_in;
            bmag     <= bmag_in;
        end else if (state == BUSY) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            data_result <= '0;
            data_valid  <= 1'b0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (accept && !start_iter) begin
                data_valid  <= 1'b1;
                data_result <= res1;
                overflow    <= ovf1;
                div_by_zero <= dbz1;
                isNotEqual  <= known && ne;
                isLessThan  <= known && lt;
            end else if (state == FINISH) begin
                data_valid  <= 1'b1;
                data_result <= is_div_q ? quo : sprod[WIDTH-1:0];
                overflow    <= is_div_q ? div_ovf : mul_ovf;
                div_by_zero <= 1'b0;
                isNotEqual  <= ne;
                isLessThan  <= lt;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 and WIDTH=16.
module tb_alu_multicycle;

    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001;
    localparam logic [4:0] AND_ = 5'b00010, OR_ = 5'b00011;
    localparam logic [4:0] SLL = 5'b00100, SRA = 5'b00101;
    localparam logic [4:0] MUL = 5'b00110, DIV = 5'b00111;
    localparam logic [4:0] SRL = 5'b01000, XOR_ = 5'b01001;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] a = '0, b = '0;
    logic [4:0]  op = '0;
    logic [4:0]  sh = '0;
    logic        valid = 1'b0;
    logic        ready, dv, ne, lt, ov, dz;
    logic [31:0] res;

    logic [15:0] a_h = '0, b_h = '0;
    logic [4:0]  op_h = '0;
    logic [3:0]  sh_h = '0;
    logic        valid_h = 1'b0;
    logic        ready_h, dv_h, ne_h, lt_h, ov_h, dz_h;
    logic [15:0] res_h;

    int tests = 0;
    int fails = 0;
    int edges, lows, pulses;

    always #5 clock = ~clock;

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock(clock), .ctrl_reset_n(rst_n),
        .data_operandA(a), .data_operandB(b),
        .ctrl_ALUopcode(op), .ctrl_shiftamt(sh),
        .ctrl_valid(valid), .ctrl_ready(ready),
        .data_result(res), .data_valid(dv),
        .isNotEqual(ne), .isLessThan(lt),
        .overflow(ov), .div_by_zero(dz)
    );

    alu_multicycle #(.WIDTH(16), .SHAMT_W(4)) dut16 (
        .clock(clock), .ctrl_reset_n(rst_n),
        .data_operandA(a_h), .data_operandB(b_h),
        .ctrl_ALUopcode(op_h), .ctrl_shiftamt(sh_h),
        .ctrl_valid(valid_h), .ctrl_ready(ready_h),
        .data_result(res_h), .data_valid(dv_h),
        .isNotEqual(ne_h), .isLessThan(lt_h),
        .overflow(ov_h), .div_by_zero(dz_h)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] s);
        op = o; a = x; b = y; sh = s; valid = 1'b1;
        @(posedge clock); #1;
        valid = 1'b0;
    endtask

    task automatic req16(input logic [4:0] o, input logic [15:0] x,
                         input logic [15:0] y);
        op_h = o; a_h = x; b_h = y; valid_h = 1'b1;
        @(posedge clock); #1;
        valid_h = 1'b0;
    endtask

    task automatic wait_done(input bit w16, output int e, output int l);
        e = 0;
        l = 0;
        while (!(w16 ? dv_h : dv) && e < 200) begin
            if (!(w16 ? ready_h : ready)) l++;
            @(posedge clock); #1;
            e++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_result", res, 32'h0);
        chk("rst_valid", {31'b0, dv}, 32'h0);
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_flags", {28'b0, ne, lt, ov, dz}, 32'h0);
        rst_n = 1'b1;

        req(ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        chk("add_valid", {31'b0, dv}, 32'h1);
        chk("add_result", res, 32'h8000_0000);
        chk("add_flags", {29'b0, ov, lt, ne}, 32'h5);
        @(posedge clock); #1;
        chk("add_pulse_once", {31'b0, dv}, 32'h0);
        chk("add_hold", res, 32'h8000_0000);

        req(SUB, 32'hFFFF_FFFF, 32'h1, 5'd0);
        chk("sub_result", res, 32'hFFFF_FFFE);
        chk("sub_flags", {29'b0, ov, lt, ne}, 32'h3);
        req(SUB, 32'h5, 32'h5, 5'd0);
        chk("sub_eq_result", res, 32'h0);
        chk("sub_eq_flags", {29'b0, ov, lt, ne}, 32'h0);

        req(5'b11111, 32'h3, 32'h3, 5'd0);
        chk("bad_op", {res[27:0], ne, lt, ov, dz}, 32'h0);
        chk("bad_op_valid", {31'b0, dv}, 32'h1);

        req(SLL, 32'h0000_0001, 32'h0, 5'd31);
        chk("sll31", res, 32'h8000_0000);

        // A stray request held high during the multiply must be dropped.
        req(MUL, 32'hFFFF_FFFD, 32'h7, 5'd0);
        op = ADD; a = 32'h1; b = 32'h1; valid = 1'b1;
        wait_done(1'b0, edges, lows);
        valid = 1'b0;
        chk("mul_latency", edges, 33);
        chk("mul_ready_low", lows, 33);
        chk("mul_ready_back", {31'b0, ready}, 32'h1);
        chk("mul_result", res, 32'hFFFF_FFEB);
        chk("mul_ovf", {31'b0, ov}, 32'h0);
        @(posedge clock); #1;
        chk("mul_stray_ignored", {31'b0, dv}, 32'h0);
        chk("mul_hold", res, 32'hFFFF_FFEB);

        req(MUL, 32'h0001_0000, 32'h0001_0000, 5'd0);
        wait_done(1'b0, edges, lows);
        chk("mul_big_result", res, 32'h0);
        chk("mul_big_ovf", {31'b0, ov}, 32'h1);

        req(DIV, 32'hFFFF_FFF9, 32'h2, 5'd0);
        wait_done(1'b0, edges, lows);
        chk("div_latency", edges, 33);
        chk("div_result", res, 32'hFFFF_FFFD);
        chk("div_flags", {28'b0, ov, lt, ne, dz}, 32'h6);

        req(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        wait_done(1'b0, edges, lows);
        chk("div_min_result", res, 32'h8000_0000);
        chk("div_min_ovf", {31'b0, ov}, 32'h1);

        req(DIV, 32'h1234, 32'h0, 5'd0);
        chk("div0_valid", {31'b0, dv}, 32'h1);
        chk("div0_result", res, 32'h0);
        chk("div0_flags", {30'b0, dz, ov}, 32'h2);
        chk("div0_ready", {31'b0, ready}, 32'h1);

        op = AND_; a = 32'hF0F0_00FF; b = 32'h0FF0_0F0F; valid = 1'b1;
        @(posedge clock); #1;
        chk("b2b_and", res, 32'h00F0_000F);
        chk("b2b_and_rdy", {30'b0, dv, ready}, 32'h3);
        op = OR_;
        @(posedge clock); #1;
        chk("b2b_or", res, 32'hFFF0_0FFF);
        chk("b2b_or_rdy", {30'b0, dv, ready}, 32'h3);
        op = XOR_;
        @(posedge clock); #1;
        chk("b2b_xor", res, 32'hFF00_0FF0);
        chk("b2b_xor_rdy", {30'b0, dv, ready}, 32'h3);
        op = SRL; a = 32'h8000_0000; sh = 5'd4;
        @(posedge clock); #1;
        chk("b2b_srl", res, 32'h0800_0000);
        chk("b2b_srl_rdy", {30'b0, dv, ready}, 32'h3);
        op = SRA;
        @(posedge clock); #1;
        valid = 1'b0;
        chk("b2b_sra", res, 32'hF800_0000);
        chk("b2b_sra_rdy", {30'b0, dv, ready}, 32'h3);

        req(MUL, 32'h0000_1234, 32'h0000_0010, 5'd0);
        repeat (10) @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready}, 32'h1);
        chk("abort_result", res, 32'h0);
        chk("abort_flags", {27'b0, dv, ne, lt, ov, dz}, 32'h0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (dv) pulses++;
            @(posedge clock); #1;
        end
        chk("abort_no_valid", pulses, 0);
        req(ADD, 32'h2, 32'h3, 5'd0);
        chk("post_rst_add", {res[30:0], dv}, {31'd5, 1'b1});

        req16(MUL, 16'hFFFD, 16'h0007);
        wait_done(1'b1, edges, lows);
        chk("w16_mul_latency", edges, 17);
        chk("w16_mul_ready_low", lows, 17);
        chk("w16_mul_result", {16'h0, res_h}, 32'h0000_FFEB);
        chk("w16_mul_ovf", {31'b0, ov_h}, 32'h0);

        req16(DIV, 16'hFFF9, 16'h0002);
        wait_done(1'b1, edges, lows);
        chk("w16_div_latency", edges, 17);
        chk("w16_div_result", {16'h0, res_h}, 32'h0000_FFFD);

        req16(MUL, 16'h0100, 16'h0100);
        wait_done(1'b1, edges, lows);
        chk("w16_mul_big", {15'h0, ov_h, res_h}, 32'h0001_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
